// File: rtl/tap_snapshot_buffer.sv
// Sample delay line with fill tracking and a handshaked snapshot streamer for the RX sample path.
// Latency: live taps update 1 cycle after rxstrobe; first snapshot word appears 1 cycle after an accepted snap_start.
// Backpressure: snapshot word/index hold while snap_valid & !snap_ready; the live line never stalls.
module tap_snapshot_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 6,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rxstrobe,
    input  logic [WIDTH-1:0] in_sample,
    output logic [WIDTH-1:0] out_sample,
    input  logic [AW-1:0]    sel,
    output logic [WIDTH-1:0] data,
    output logic             primed,
    input  logic             snap_start,
    output logic             snap_busy,
    output logic [WIDTH-1:0] snap_data,
    output logic             snap_valid,
    input  logic             snap_ready,
    output logic             snap_last
);
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [CW-1:0] FILL_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

    logic [WIDTH-1:0] taps [DEPTH];
    logic [WIDTH-1:0] snap [DEPTH];
    logic [CW-1:0]    fill_cnt;
    logic [AW-1:0]    idx;
    logic [0:0]       state;

    // Live delay line: shift newest sample into tap 0 on every strobe.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps[i] <= '0;
            end
        end else if (rxstrobe) begin
            taps[0] <= in_sample;
            for (int i = 1; i < DEPTH; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // Fill counter saturates at DEPTH; primed means the whole window holds real samples.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fill_cnt <= '0;
        end else if (rxstrobe && (fill_cnt != FILL_FULL)) begin
            fill_cnt <= fill_cnt + CW'(1);
        end
    end

    assign primed = (fill_cnt == FILL_FULL);

    // Snapshot engine: capture the pre-shift window on accept, then stream tap 0..DEPTH-1.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            idx   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                snap[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (snap_start && primed) begin
                        for (int i = 0; i < DEPTH; i++) begin
                            snap[i] <= taps[i];
                        end
                        idx   <= '0;
                        state <= ST_STREAM;
                    end
                end
                default: begin
                    if (snap_ready) begin
                        if (idx == LAST_IDX) begin
                            state <= ST_IDLE;
                        end else begin
                            idx <= idx + AW'(1);
                        end
                    end
                end
            endcase
        end
    end

    // Combinational tap selects; out-of-range sel reads as zero.
    always_comb begin
        data      = '0;
        snap_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel == AW'(i)) begin
                data = taps[i];
            end
            if (idx == AW'(i)) begin
                snap_data = snap[i];
            end
        end
    end

    assign out_sample = taps[DEPTH-1];
    assign snap_valid = (state == ST_STREAM);
    assign snap_busy  = (state == ST_STREAM);
    assign snap_last  = (state == ST_STREAM) && (idx == LAST_IDX);

endmodule

// File: tb/tb_tap_snapshot_buffer.sv
// Bench for tap_snapshot_buffer: directed scenarios plus randomized traffic.
// A queue-based window/stream model is compared against the DUT every negedge.
// Literal expectations in the directed part pin the model itself.
module tb_tap_snapshot_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 6;
    localparam int AW    = 3;

    logic             clk;
    logic             reset;
    logic             rxstrobe;
    logic [WIDTH-1:0] in_sample;
    logic [WIDTH-1:0] out_sample;
    logic [AW-1:0]    sel;
    logic [WIDTH-1:0] data;
    logic             primed;
    logic             snap_start;
    logic             snap_busy;
    logic [WIDTH-1:0] snap_data;
    logic             snap_valid;
    logic             snap_ready;
    logic             snap_last;

    tap_snapshot_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .rxstrobe   (rxstrobe),
        .in_sample  (in_sample),
        .out_sample (out_sample),
        .sel        (sel),
        .data       (data),
        .primed     (primed),
        .snap_start (snap_start),
        .snap_busy  (snap_busy),
        .snap_data  (snap_data),
        .snap_valid (snap_valid),
        .snap_ready (snap_ready),
        .snap_last  (snap_last)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit run_cmp  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [WIDTH-1:0] hist[$];    // strobed samples, newest first, at most DEPTH kept
    logic [WIDTH-1:0] exp_q[$];   // remaining words of the current snapshot stream
    int               nstrobe;    // strobes since reset, saturating at DEPTH
    bit               zero_snap;  // no capture since reset: snapshot regs still zero
    logic [WIDTH-1:0] dump;

    function automatic logic [WIDTH-1:0] tap_of(input int i);
        if (i < hist.size()) return hist[i];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            hist.delete();
            exp_q.delete();
            nstrobe   = 0;
            zero_snap = 1'b1;
        end else begin
            if (exp_q.size() != 0) begin
                if (snap_ready) dump = exp_q.pop_front();
            end else if (snap_start && nstrobe >= DEPTH) begin
                for (int i = 0; i < DEPTH; i++) exp_q.push_back(tap_of(i));
                zero_snap = 1'b0;
            end
            if (rxstrobe) begin
                hist.push_front(in_sample);
                if (hist.size() > DEPTH) dump = hist.pop_back();
                if (nstrobe < DEPTH) nstrobe++;
            end
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("m_out_sample", 32'(out_sample), 32'(tap_of(DEPTH-1)));
            chk("m_data", 32'(data), (int'(sel) < DEPTH) ? 32'(tap_of(int'(sel))) : 32'd0);
            chk("m_primed", 32'(primed), 32'(nstrobe >= DEPTH));
            chk("m_snap_valid", 32'(snap_valid), 32'(exp_q.size() != 0));
            chk("m_snap_busy", 32'(snap_busy), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("m_snap_data", 32'(snap_data), 32'(exp_q[0]));
                chk("m_snap_last", 32'(snap_last), 32'(exp_q.size() == 1));
            end else begin
                chk("m_snap_last_idle", 32'(snap_last), 32'd0);
                if (zero_snap) chk("m_snap_data_rst", 32'(snap_data), 32'd0);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_1_to_6();
        for (int v = 1; v <= DEPTH; v++) begin
            rxstrobe  = 1'b1;
            in_sample = WIDTH'(v);
            tick();
        end
        rxstrobe = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    int         hs;
    int         vcnt;
    logic [3:0] rpat;
    logic [WIDTH-1:0] bp_words [DEPTH];

    initial begin
        reset      = 1'b0;
        rxstrobe   = 1'b0;
        in_sample  = '0;
        sel        = '0;
        snap_start = 1'b0;
        snap_ready = 1'b0;
        tick();
        run_cmp = 1'b1;
        tick();

        // Reset values
        chk("rst_out_sample", 32'(out_sample), 32'd0);
        chk("rst_data", 32'(data), 32'd0);
        chk("rst_primed", 32'(primed), 32'd0);
        chk("rst_snap_valid", 32'(snap_valid), 32'd0);
        chk("rst_snap_busy", 32'(snap_busy), 32'd0);
        chk("rst_snap_last", 32'(snap_last), 32'd0);
        chk("rst_snap_data", 32'(snap_data), 32'd0);
        reset = 1'b1;

        // Fill/shift
        for (int v = 1; v <= DEPTH; v++) begin
            rxstrobe  = 1'b1;
            in_sample = WIDTH'(v);
            tick();
            chk("fill_primed", 32'(primed), 32'(v == DEPTH));
        end
        rxstrobe = 1'b0;
        chk("fill_out_sample", 32'(out_sample), 32'd1);
        for (int s = 0; s < 8; s++) begin
            sel = AW'(s);
            tick();
            chk("fill_sel_data", 32'(data), (s < DEPTH) ? 32'(DEPTH - s) : 32'd0);
        end
        sel       = '0;
        rxstrobe  = 1'b1;
        in_sample = 8'd7;
        tick();
        rxstrobe = 1'b0;
        chk("shift7_out_sample", 32'(out_sample), 32'd2);

        // Start before primed is ignored and not remembered
        do_reset();
        for (int v = 1; v <= 3; v++) begin
            rxstrobe  = 1'b1;
            in_sample = WIDTH'(v);
            tick();
        end
        rxstrobe   = 1'b0;
        snap_start = 1'b1;
        tick();
        snap_start = 1'b0;
        vcnt = 0;
        for (int v = 4; v <= 9; v++) begin
            rxstrobe  = 1'b1;
            in_sample = WIDTH'(v);
            if (snap_valid) vcnt++;
            tick();
        end
        rxstrobe = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (snap_valid) vcnt++;
            tick();
        end
        chk("early_start_ignored", 32'(vcnt), 32'd0);

        // Coherent snapshot: start and strobe in the same cycle
        do_reset();
        fill_1_to_6();
        snap_start = 1'b1;
        snap_ready = 1'b1;
        rxstrobe   = 1'b1;
        in_sample  = 8'd9;
        tick();
        snap_start = 1'b0;
        rxstrobe   = 1'b0;
        sel        = '0;
        chk("coh_live_tap0", 32'(data), 32'd9);
        for (int k = 0; k < DEPTH; k++) begin
            chk("coh_valid", 32'(snap_valid), 32'd1);
            chk("coh_word", 32'(snap_data), 32'(DEPTH - k));
            chk("coh_last", 32'(snap_last), 32'(k == DEPTH - 1));
            tick();
        end
        chk("coh_valid_fall", 32'(snap_valid), 32'd0);

        // Backpressure: window is now 9,6,5,4,3,2
        bp_words[0] = 8'd9; bp_words[1] = 8'd6; bp_words[2] = 8'd5;
        bp_words[3] = 8'd4; bp_words[4] = 8'd3; bp_words[5] = 8'd2;
        rpat       = 4'b1001;   // bit k%4 gives ready: 1,0,0,1
        snap_ready = 1'b0;
        snap_start = 1'b1;
        tick();
        snap_start = 1'b0;
        hs = 0;
        for (int k = 0; k < 40; k++) begin
            if (!snap_valid) break;
            snap_ready = rpat[k % 4];
            if (hs < DEPTH) chk("bp_word", 32'(snap_data), 32'(bp_words[hs]));
            if (snap_ready) hs++;
            tick();
        end
        chk("bp_handshakes", 32'(hs), 32'(DEPTH));
        chk("bp_idle_after", 32'(snap_valid), 32'd0);

        // Reset mid-stream after the 2nd word
        snap_ready = 1'b1;
        snap_start = 1'b1;
        tick();
        snap_start = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("rms_valid", 32'(snap_valid), 32'd0);
        chk("rms_primed", 32'(primed), 32'd0);
        chk("rms_out_sample", 32'(out_sample), 32'd0);
        chk("rms_snap_data", 32'(snap_data), 32'd0);
        reset      = 1'b1;
        snap_start = 1'b1;
        vcnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (snap_valid) vcnt++;
        end
        snap_start = 1'b0;
        chk("rms_start_ignored", 32'(vcnt), 32'd0);

        // Back-to-back with snap_start held high
        fill_1_to_6();
        snap_ready = 1'b1;
        snap_start = 1'b1;
        tick();
        for (int k = 0; k < 21; k++) begin
            chk("b2b_valid", 32'(snap_valid), 32'((k % 7) != 6));
            tick();
        end
        snap_start = 1'b0;
        for (int k = 0; k < 8; k++) tick();

        // Randomized traffic, checked by the model every cycle
        for (int k = 0; k < 3000; k++) begin
            reset      = ($urandom_range(0, 299) != 0);
            rxstrobe   = $urandom_range(0, 1) != 0;
            in_sample  = WIDTH'($urandom);
            sel        = AW'($urandom);
            snap_start = ($urandom_range(0, 7) == 0);
            snap_ready = ($urandom_range(0, 3) != 0);
            tick();
        end

        run_cmp = 1'b0;
        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end
endmodule

// File: doc/tap_snapshot_buffer.md
# tap_snapshot_buffer

Parametrised sample delay line for the inband receive path. It keeps the most recent DEPTH samples and exposes the oldest sample and one randomly selected tap combinationally. It also adds fill tracking and a handshaked snapshot engine that freezes all taps and streams them out one per cycle. The block sits between the decimated RX sample stream and the matched-filter/correlator logic, which needs a coherent copy of the window while the live line keeps shifting.

## Interface
- WIDTH, 8: sample width in bits (two's complement).
- DEPTH, 6: number of taps; minimum 2.
- AW, 3: tap index width; must satisfy 2^AW >= DEPTH.

- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on rising clk).
- rxstrobe  in  1  sample-enable; shifts the line when high.
- in_sample  in  WIDTH  new sample, written to tap 0 on rxstrobe.
- out_sample  out  WIDTH  tap DEPTH-1 (oldest), combinational from the tap register.
- sel  in  AW  live tap index for data.
- data  out  WIDTH  tap[sel]; 0 when sel >= DEPTH; combinational.
- primed  out  1  high once DEPTH samples have been shifted in since reset; registered.
- snap_start  in  1  request to capture and stream the window.
- snap_busy  out  1  high while the snapshot engine is in STREAM.
- snap_data  out  WIDTH  current snapshot word.
- snap_valid  out  1  snap_data valid.
- snap_ready  in  1  consumer accepts the word when snap_valid & snap_ready.
- snap_last  out  1  high with the final word (tap DEPTH-1).

## Operation
- Live line: on rxstrobe, tap[i] <= tap[i-1] for i = 1..DEPTH-1, and tap[0] <= in_sample. Without rxstrobe the taps hold.
- Fill counter: width clog2(DEPTH+1). It increments on each rxstrobe and saturates at DEPTH. primed = (count == DEPTH).
- Snapshot FSM has two states, IDLE and STREAM.
  - IDLE: snap_valid = 0, snap_busy = 0. If snap_start & primed, then at that edge:
    - copy all live taps into the snapshot registers, taking pre-shift values if rxstrobe is high in the same cycle;
    - set the read index to 0;
    - go to STREAM.
  - IDLE: snap_start while not primed is ignored and not remembered.
  - STREAM: snap_valid = 1, snap_busy = 1, snap_data = snap[idx], snap_last = (idx == DEPTH-1).
    - On a handshake with idx < DEPTH-1: idx increments.
    - On a handshake with idx == DEPTH-1: go to IDLE.
    - Without a handshake: idx, snap_data and snap_last hold.
    - snap_start is ignored.
- Stream order is tap 0 (newest) first, tap DEPTH-1 (oldest) last.
- The live line, fill counter, out_sample and data keep operating during STREAM. The snapshot contents are unaffected by them.
- reset low, including mid-stream: all taps, snapshot registers, the counter and idx go to 0 and the state goes to IDLE.
- Output values during and after reset: out_sample = 0, data = 0, primed = 0, snap_valid = 0, snap_busy = 0, snap_last = 0, snap_data = 0.

## Timing
- Shift latency: in_sample is visible on data with sel = 0 the cycle after the rxstrobe edge. It reaches out_sample after DEPTH strobes.
- primed rises in the cycle after the DEPTH-th rxstrobe edge.
- snap_valid rises the cycle after snap_start is accepted.
- With snap_ready held high, the stream takes DEPTH consecutive cycles and snap_valid falls the cycle after the last word.
- Earliest re-accept of snap_start: the first IDLE cycle after the last handshake, so there is a 1-cycle minimum gap between streams.
- snap_data, snap_valid and snap_last are registered or derived only from registered state. There is no combinational path from snap_ready to snap_valid.
- When reset deasserts at an edge, the first rxstrobe is honoured at the following edge.

## Test plan
- Fill/shift:
  - Stimulus: reset, then 6 strobes of 1..6 (WIDTH=8, DEPTH=6).
  - Response: out_sample = 1; data with sel = 0..5 gives 6,5,4,3,2,1; sel = 6 and 7 give 0; primed rises after the 6th strobe; a 7th strobe of 7 gives out_sample = 2.
- Start before primed:
  - Stimulus: snap_start after 3 strobes.
  - Response: snap_valid stays 0 and no later stream occurs without a new start.
- Coherent snapshot:
  - Stimulus: after 1..6, snap_start and rxstrobe(9) in the same cycle, with snap_ready = 1.
  - Response: stream 6,5,4,3,2,1; snap_last only on 1; the live tap 0 = 9.
- Backpressure:
  - Stimulus: toggle snap_ready 1,0,0,1,... during a stream.
  - Response: each word is held stable while not ready; exactly 6 handshakes; return to IDLE after the last.
- Reset mid-stream:
  - Stimulus: drive reset low after the 2nd word.
  - Response: next cycle snap_valid = 0, primed = 0, out_sample = 0; a later snap_start without 6 new strobes is ignored.
- Back-to-back:
  - Stimulus: snap_start held high continuously.
  - Response: streams of 6 words separated by exactly one idle cycle.
